// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU sequencing controller: state encoding,
// operation codes and ULA command codes.
package fpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ALIGN,
        S_EXEC,
        S_MUL_WAIT,
        S_NORM,
        S_DONE
    } fpu_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] ULA_NONE = 2'b00;
    localparam logic [1:0] ULA_ADD  = 2'b01;
    localparam logic [1:0] ULA_SUB  = 2'b10;

    function automatic logic [1:0] ula_for(input logic signs_differ);
        return signs_differ ? ULA_SUB : ULA_ADD;
    endfunction

endpackage

// File: rtl/fpu_seq_ctrl_if.sv
// Start/done handshake, datapath status flags and datapath/multiplier
// control strobes of the FPU sequencing controller.
interface fpu_seq_ctrl_if #(
    parameter int EXP_W = 8
);
    logic             start;
    logic [1:0]       op;
    logic             sign_a;
    logic             sign_b;
    logic             a_smaller;
    logic [EXP_W-1:0] exp_diff;
    logic             done_mult;
    logic             sum_carry;
    logic             sum_msb;
    logic             sum_zero;

    logic             busy;
    logic             done;
    logic             error;
    logic             load_operands;
    logic             swap;
    logic             align_shift;
    logic [1:0]       ula_cmd;
    logic             diferen_signs;
    logic             start_mult;
    logic             norm_right;
    logic             norm_left;
    logic             result_sign;

    modport master (
        output start, op, sign_a, sign_b, a_smaller, exp_diff,
               done_mult, sum_carry, sum_msb, sum_zero,
        input  busy, done, error, load_operands, swap, align_shift, ula_cmd,
               diferen_signs, start_mult, norm_right, norm_left, result_sign
    );

    modport slave (
        input  start, op, sign_a, sign_b, a_smaller, exp_diff,
               done_mult, sum_carry, sum_msb, sum_zero,
        output busy, done, error, load_operands, swap, align_shift, ula_cmd,
               diferen_signs, start_mult, norm_right, norm_left, result_sign
    );
endinterface

// File: rtl/fpu_step_counter.sv
// Loadable up/down step counter; at_term flags when the count equals term_val.
module fpu_step_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term_val,
    output logic         at_term
);
    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    assign at_term = (count == term_val);
endmodule

// File: rtl/fpu_seq_ctrl.sv
// Sequences one add/sub/mult through load, alignment, ULA or multiplier
// handshake and normalisation, then pulses done (with error if it failed).
//
// state      | meaning
// S_IDLE     | waiting for start; operands captured on the start edge
// S_LOAD     | datapath loads operands; signs resolved, counters primed
// S_ALIGN    | smaller mantissa shifted right once per cycle
// S_EXEC     | ULA add or subtract for one cycle
// S_MUL_WAIT | waiting for done_mult, bounded by MULT_TIMEOUT
// S_NORM     | result normalised one step per cycle
// S_DONE     | done pulse, error valid
module fpu_seq_ctrl
    import fpu_pkg::*;
#(
    parameter int EXP_W        = 8,
    parameter int MANT_W       = 23,
    parameter int MULT_TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset_n,
    fpu_seq_ctrl_if.slave bus
);
    localparam int ALIGN_W = $clog2(MANT_W + 3);
    localparam int NORM_W  = $clog2(MANT_W + 1);
    localparam int TMO_W   = $clog2(MULT_TIMEOUT + 1);

    fpu_state_t       state;
    logic [1:0]       op_q;
    logic             sign_a_q, sign_b_q, a_smaller_q;
    logic [EXP_W-1:0] exp_diff_q;

    logic       busy_q, done_q, error_q, load_q, align_q, dif_q, start_mult_q, rsign_q;
    logic [1:0] ula_q;

    logic               eff_b;
    logic [ALIGN_W-1:0] align_init;
    logic               align_term, norm_term, tmo_term;
    logic               norm_right, norm_left;

    assign eff_b      = sign_b_q ^ (op_q == OP_SUB);
    // Shifting past the hidden and guard positions changes nothing, so saturate.
    assign align_init = (32'(exp_diff_q) > MANT_W + 2) ? ALIGN_W'(MANT_W + 2)
                                                        : ALIGN_W'(exp_diff_q);

    assign norm_right = (state == S_NORM) && !bus.sum_zero && bus.sum_carry;
    assign norm_left  = (state == S_NORM) && !bus.sum_zero && !bus.sum_carry && !bus.sum_msb;

    fpu_step_counter #(.W(ALIGN_W)) u_align_cnt (
        .clock(clock), .reset_n(reset_n),
        .load(state == S_LOAD), .load_val(align_init),
        .en(state == S_ALIGN), .up(1'b0),
        .term_val(ALIGN_W'(1)), .at_term(align_term)
    );

    fpu_step_counter #(.W(NORM_W)) u_norm_cnt (
        .clock(clock), .reset_n(reset_n),
        .load(state == S_LOAD), .load_val('0),
        .en(norm_left), .up(1'b1),
        .term_val(NORM_W'(MANT_W - 1)), .at_term(norm_term)
    );

    fpu_step_counter #(.W(TMO_W)) u_tmo_cnt (
        .clock(clock), .reset_n(reset_n),
        .load(state == S_LOAD), .load_val('0),
        .en(state == S_MUL_WAIT), .up(1'b1),
        .term_val(TMO_W'(MULT_TIMEOUT - 1)), .at_term(tmo_term)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            op_q         <= OP_ADD;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            a_smaller_q  <= 1'b0;
            exp_diff_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            load_q       <= 1'b0;
            align_q      <= 1'b0;
            ula_q        <= ULA_NONE;
            dif_q        <= 1'b0;
            start_mult_q <= 1'b0;
            rsign_q      <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            load_q       <= 1'b0;
            align_q      <= 1'b0;
            ula_q        <= ULA_NONE;
            start_mult_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q        <= bus.op;
                        sign_a_q    <= bus.sign_a;
                        sign_b_q    <= bus.sign_b;
                        a_smaller_q <= bus.a_smaller;
                        exp_diff_q  <= bus.exp_diff;
                        load_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dif_q   <= sign_a_q ^ eff_b;
                    rsign_q <= (op_q == OP_MUL) ? (sign_a_q ^ sign_b_q)
                                                : (a_smaller_q ? eff_b : sign_a_q);
                    if (op_q == OP_ILL) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state   <= S_DONE;
                    end else if (op_q == OP_MUL) begin
                        start_mult_q <= 1'b1;
                        state        <= S_MUL_WAIT;
                    end else if (exp_diff_q == '0) begin
                        ula_q <= ula_for(sign_a_q ^ eff_b);
                        state <= S_EXEC;
                    end else begin
                        align_q <= 1'b1;
                        state   <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (align_term) begin
                        ula_q <= ula_for(dif_q);
                        state <= S_EXEC;
                    end else begin
                        align_q <= 1'b1;
                    end
                end
                S_EXEC: state <= S_NORM;
                S_NORM: begin
                    if (bus.sum_zero || bus.sum_carry || bus.sum_msb || norm_term) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                    if (bus.sum_zero)
                        rsign_q <= 1'b0;
                end
                S_MUL_WAIT: begin
                    // done_mult wins over a timeout landing in the same cycle
                    if (bus.done_mult || tmo_term) begin
                        done_q  <= 1'b1;
                        error_q <= !bus.done_mult;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.load_operands = load_q;
    assign bus.swap          = a_smaller_q;
    assign bus.align_shift   = align_q;
    assign bus.ula_cmd       = ula_q;
    assign bus.diferen_signs = dif_q;
    assign bus.start_mult    = start_mult_q;
    assign bus.norm_right    = norm_right;
    assign bus.norm_left     = norm_left;
    assign bus.result_sign   = rsign_q;
endmodule
